// File: rtl/prio_enc_scan_if.sv
// Bundle of request, encoded-result and seven-segment display signals
// for the prio_enc_scan block. The master side drives requests and hold;
// the slave side (the encoder) drives the result and the display pins.
interface prio_enc_scan_if #(
   parameter int WIDTH = 16
);
   localparam int IDX_W = $clog2(WIDTH);

   logic [WIDTH-1:0] din;       // request lines
   logic             hold;      // freeze dout/valid
   logic [IDX_W-1:0] dout;      // encoded winning index
   logic             valid;     // at least one request was set
   logic [7:0]       segments;  // {dp,g,f,e,d,c,b,a}, active-low
   logic [3:0]       anodes;    // digit enables, active-low

   modport master (
      output din,
      output hold,
      input  dout,
      input  valid,
      input  segments,
      input  anodes
   );

   modport slave (
      input  din,
      input  hold,
      output dout,
      output valid,
      output segments,
      output anodes
   );
endinterface

// File: rtl/prio_enc_scan.sv
// Registered priority encoder over WIDTH request lines with selectable
// priority direction and a hold mode. The winning index is also shown in
// hex on a 4-digit multiplexed seven-segment display (ptr 0 = rightmost).
// Every output comes straight from a flop; din and hold only reach the
// outputs through din_q and the dout/valid registers.
module prio_enc_scan #(
   parameter int WIDTH          = 16,
   parameter int SCAN_DIV       = 50000,
   parameter int LOW_PRIO_FIRST = 0
) (
   input logic           clk,
   input logic           rst_n,
   prio_enc_scan_if.slave bus
);
   localparam int IDX_W   = $clog2(WIDTH);
   localparam int PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
   localparam logic [6:0]         GLYPH_DASH  = 7'b0111111;
   localparam logic [6:0]         GLYPH_BLANK = 7'b1111111;

   // Hex digit to active-low gfedcba pattern.
   function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
      case (nib)
         4'h0:    return 7'b1000000;
         4'h1:    return 7'b1111001;
         4'h2:    return 7'b0100100;
         4'h3:    return 7'b0110000;
         4'h4:    return 7'b0011001;
         4'h5:    return 7'b0010010;
         4'h6:    return 7'b0000010;
         4'h7:    return 7'b1111000;
         4'h8:    return 7'b0000000;
         4'h9:    return 7'b0010000;
         4'hA:    return 7'b0001000;
         4'hB:    return 7'b0000011;
         4'hC:    return 7'b1000110;
         4'hD:    return 7'b0100001;
         4'hE:    return 7'b0000110;
         4'hF:    return 7'b0001110;
         default: return 7'b1111111;
      endcase
   endfunction

   // Full segment byte (dp off) for digit position p given the index and valid.
   function automatic logic [7:0] digit_seg(input logic [1:0] p,
                                            input logic [7:0] idx,
                                            input logic       vld);
      logic [6:0] g;
      g = GLYPH_BLANK;
      if (!vld) begin
         g = GLYPH_DASH;
      end else begin
         case (p)
            2'd0:    g = hex_glyph(idx[3:0]);
            2'd1:    g = (IDX_W <= 4) ? GLYPH_BLANK : hex_glyph(idx[7:4]);
            default: g = GLYPH_BLANK;
         endcase
      end
      return {1'b1, g};
   endfunction

   logic [WIDTH-1:0]   din_q,      din_d;
   logic [IDX_W-1:0]   dout_q,     dout_d;
   logic               valid_q,    valid_d;
   logic [PRESC_W-1:0] presc_q,    presc_d;
   logic [1:0]         ptr_q,      ptr_d;
   logic [3:0]         anodes_q,   anodes_d;
   logic [7:0]         segments_q, segments_d;

   logic [IDX_W-1:0]   enc_idx_s;
   logic               enc_hit_s;

   // Priority encode the sampled requests; the last set bit visited wins.
   always_comb begin
      enc_idx_s = '0;
      enc_hit_s = 1'b0;
      if (LOW_PRIO_FIRST != 0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            enc_idx_s = din_q[i] ? IDX_W'(i) : enc_idx_s;
            enc_hit_s = enc_hit_s | din_q[i];
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            enc_idx_s = din_q[i] ? IDX_W'(i) : enc_idx_s;
            enc_hit_s = enc_hit_s | din_q[i];
         end
      end
   end

   // Input sampling and result register with hold; din_q keeps sampling while held.
   always_comb begin
      din_d   = bus.din;
      dout_d  = dout_q;
      valid_d = valid_q;
      if (bus.hold) begin
         dout_d  = dout_q;
         valid_d = valid_q;
      end else begin
         dout_d  = enc_idx_s;
         valid_d = enc_hit_s;
      end
   end

   // Display scan: on prescaler wrap advance the digit and load anodes and segments together.
   always_comb begin
      presc_d    = presc_q + PRESC_W'(1);
      ptr_d      = ptr_q;
      anodes_d   = anodes_q;
      segments_d = segments_q;
      if (presc_q == PRESC_LAST) begin
         presc_d    = '0;
         ptr_d      = ptr_q + 2'd1;
         anodes_d   = ~(4'b0001 << ptr_d);
         segments_d = digit_seg(ptr_d, 8'(dout_q), valid_q);
      end else begin
         ptr_d      = ptr_q;
         anodes_d   = anodes_q;
         segments_d = segments_q;
      end
   end

   // State registers with asynchronous reset to digit 0, blank, no result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         din_q      <= '0;
         dout_q     <= '0;
         valid_q    <= 1'b0;
         presc_q    <= '0;
         ptr_q      <= 2'd0;
         anodes_q   <= 4'b1110;
         segments_q <= 8'hFF;
      end else begin
         din_q      <= din_d;
         dout_q     <= dout_d;
         valid_q    <= valid_d;
         presc_q    <= presc_d;
         ptr_q      <= ptr_d;
         anodes_q   <= anodes_d;
         segments_q <= segments_d;
      end
   end

   assign bus.dout     = dout_q;
   assign bus.valid    = valid_q;
   assign bus.segments = segments_q;
   assign bus.anodes   = anodes_q;

endmodule
